// File: rtl/rom_burst_sched.sv
// Burst-read scheduler: two requesters share one coefficient ROM; each burst of
// 1..8 words is read one word per cycle and handed over as one 8-slot vector.
module rom_burst_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int ROM_DEPTH  = 256,
   parameter int ADDR_WIDTH = $clog2(ROM_DEPTH),
   parameter int BURST_MAX  = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            req0_valid,
   input  logic [ADDR_WIDTH-1:0]           req0_addr,
   input  logic [2:0]                      req0_len,
   output logic                            req0_ready,
   input  logic                            req1_valid,
   input  logic [ADDR_WIDTH-1:0]           req1_addr,
   input  logic [2:0]                      req1_len,
   output logic                            req1_ready,
   output logic                            rom_en,
   output logic [ADDR_WIDTH-1:0]           rom_addr,
   input  logic [DATA_WIDTH-1:0]           rom_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [BURST_MAX*DATA_WIDTH-1:0] out_data,
   output logic                            out_src,
   output logic [3:0]                      out_len,
   output logic                            busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]            state_reg, state_next;
   logic                  prio_reg;
   logic                  src_reg;
   logic [ADDR_WIDTH-1:0] base_reg;
   logic [ADDR_WIDTH-1:0] last_addr_reg;
   logic [3:0]            len_reg;
   logic [3:0]            k_reg;
   logic                  grant0, grant1, grant_any;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [BURST_MAX-1:0]  slot_cap;

   // Readies are forced low while reset is high so nothing is accepted into a clearing block.
   assign grant0    = (state_reg == IDLE) && !reset && req0_valid && (!req1_valid || !prio_reg);
   assign grant1    = (state_reg == IDLE) && !reset && req1_valid && (!req0_valid ||  prio_reg);
   assign grant_any = grant0 || grant1;

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign issue_addr = base_reg + ADDR_WIDTH'(k_reg);
   assign rom_en     = (state_reg == ISSUE);
   assign rom_addr   = rom_en ? issue_addr : last_addr_reg;
   assign out_valid  = (state_reg == HOLD);
   assign out_src    = src_reg;
   assign out_len    = len_reg;
   assign busy       = (state_reg != IDLE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any) state_next = ISSUE;
         ISSUE:   if (k_reg == len_reg - 4'd1) state_next = DRAIN;
         DRAIN:   state_next = HOLD;
         HOLD:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         prio_reg      <= 1'b0;
         src_reg       <= 1'b0;
         base_reg      <= '0;
         last_addr_reg <= '0;
         len_reg       <= 4'd0;
         k_reg         <= 4'd0;
      end else begin
         state_reg <= state_next;
         if (grant_any) begin
            base_reg <= grant1 ? req1_addr : req0_addr;
            len_reg  <= 4'(grant1 ? req1_len : req0_len) + 4'd1;
            src_reg  <= grant1;
            prio_reg <= !grant1;
            k_reg    <= 4'd0;
         end
         if (state_reg == ISSUE) begin
            last_addr_reg <= issue_addr;
            k_reg         <= k_reg + 4'd1;
         end
      end
   end

   // ROM data lags its address by one cycle: issue k fills slot k-1, DRAIN fills the last slot.
   for (genvar gi = 0; gi < BURST_MAX; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_reg;

      assign slot_cap[gi] = ((state_reg == ISSUE) && (k_reg == 4'(gi + 1))) ||
                            ((state_reg == DRAIN) && (len_reg == 4'(gi + 1)));

      always_ff @(posedge clk) begin
         if (reset || grant_any) begin
            slot_reg <= '0;
         end else if (slot_cap[gi]) begin
            slot_reg <= rom_data;
         end
      end

      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
   end

endmodule

// File: tb/tb_rom_burst_sched.sv
// Randomised scoreboard bench for rom_burst_sched with a schedule-level reference model.
module tb_rom_burst_sched;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BM = 8;

   typedef struct {
      logic         src;
      logic [3:0]   len;
      logic [255:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req0_valid = 1'b0, req1_valid = 1'b0;
   logic [AW-1:0]     req0_addr = '0, req1_addr = '0;
   logic [2:0]        req0_len = '0, req1_len = '0;
   logic              req0_ready, req1_ready;
   logic              rom_en;
   logic [AW-1:0]     rom_addr;
   logic [DW-1:0]     rom_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [BM*DW-1:0]  out_data;
   logic              out_src;
   logic [3:0]        out_len;
   logic              busy;

   int   n_cmp = 0, n_err = 0;
   int   cyc = 0;
   logic reset_q = 1'b0;

   // Reference model state
   bit   m_busy = 0, m_prio = 0, acc0 = 0, acc1 = 0, exp_ov = 0, b2b_mode = 0;
   int   m_t = 0, m_base = 0, m_len = 0, m_last = 0, last_acc = -1;
   exp_t exp_q[$];

   rom_burst_sched dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_src(out_src), .out_len(out_len), .busy(busy)
   );

   always #5 clk = ~clk;

   // ROM with one cycle of read latency; garbage when not read so stray captures show up.
   always @(posedge clk) begin
      rom_data <= rom_en ? (32'h1000 + 32'(rom_addr)) : 32'hDEAD_BEEF;
      cyc      <= cyc + 1;
      reset_q  <= reset;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [255:0] burst_words(input int base, input int len);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < len; i++) v[i*32 +: 32] = 32'h1000 + 32'((base + i) % 256);
      return v;
   endfunction

   // Model: predicts handshakes, ROM schedule and output timing from the burst rules.
   always @(negedge clk) begin
      bit   exp_en, g0, g1;
      int   exp_addr;
      exp_t e;
      exp_en   = m_busy && (cyc >= m_t + 1) && (cyc <= m_t + m_len);
      exp_addr = exp_en ? (m_base + cyc - m_t - 1) % 256 : m_last;
      exp_ov   = m_busy && (cyc >= m_t + m_len + 2);
      g0 = !reset && !m_busy && req0_valid && (!req1_valid || !m_prio);
      g1 = !reset && !m_busy && req1_valid && (!req0_valid ||  m_prio);
      if (reset_q) begin
         chk("reset_out_data", out_data, '0);
         chk("reset_out_src", out_src, 0);
         chk("reset_out_len", out_len, 0);
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("rom_en", rom_en, exp_en);
      chk("rom_addr", rom_addr, exp_addr);
      chk("out_valid", out_valid, exp_ov);
      chk("busy", busy, m_busy);
      acc0 = g0;
      acc1 = g1;
      if (!b2b_mode) last_acc = -1;
      if (reset) begin
         m_busy = 0; m_prio = 0; m_last = 0;
         exp_q.delete();
      end else begin
         if (exp_en) m_last = exp_addr;
         if (exp_ov && out_ready) m_busy = 0;
         if (g0 || g1) begin
            m_busy = 1;
            m_t    = cyc;
            m_base = g1 ? int'(req1_addr) : int'(req0_addr);
            m_len  = (g1 ? int'(req1_len) : int'(req0_len)) + 1;
            m_prio = !g1;
            e.src  = g1;
            e.len  = 4'(m_len);
            e.data = burst_words(m_base, m_len);
            exp_q.push_back(e);
            if (b2b_mode) begin
               if (last_acc >= 0) chk("b2b_interval", 32'(cyc - last_acc), 4);
               last_acc = cyc;
            end
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the scoreboard head.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
         end else begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_src", out_src, exp_q[0].src);
            chk("out_len", out_len, exp_q[0].len);
            if (out_ready) begin
               $display("burst src=%0d len=%0d data=%0h", out_src, out_len, out_data);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic post(input bit n, input logic [7:0] a, input logic [2:0] l);
      bit done;
      done = 0;
      if (!n) begin req0_valid = 1; req0_addr = a; req0_len = l; end
      else    begin req1_valid = 1; req1_addr = a; req1_len = l; end
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         done = n ? acc1 : acc0;
      end
      if (!n) req0_valid = 0; else req1_valid = 0;
      chk("post_accepted", done, 1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         done = !m_busy;
      end
      chk("wait_idle_done", done, 1);
   endtask

   initial begin
      bit done;
      int n, exp_src;
      repeat (3) tick();
      reset = 0;
      tick();
      // Single 8-word burst, then address wrap on requester 1
      out_ready = 1;
      post(0, 8'h10, 3'd7);
      wait_idle();
      post(1, 8'hFE, 3'd3);
      wait_idle();
      // Arbitration: both held valid, grants must alternate starting with req0
      req0_addr = 8'h05; req0_len = 3'd0; req1_addr = 8'h50; req1_len = 3'd1;
      req0_valid = 1; req1_valid = 1;
      n = 0; exp_src = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         tick();
         if (acc0 || acc1) begin
            chk("arb_grant_src", acc1, exp_src);
            exp_src = 1 - exp_src;
            n++;
         end
      end
      req0_valid = 0; req1_valid = 0;
      chk("arb_grant_count", n, 4);
      wait_idle();
      // Backpressure: hold 5 cycles in HOLD with req1 waiting
      out_ready = 0;
      post(0, 8'h80, 3'd2);
      req1_valid = 1; req1_addr = 8'h33; req1_len = 3'd0;
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         tick();
         done = exp_ov;
      end
      chk("hold_reached", done, 1);
      repeat (5) tick();
      out_ready = 1;
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         tick();
         done = acc1;
      end
      req1_valid = 0;
      chk("post_hold_accept", done, 1);
      wait_idle();
      // Mid-burst reset during the ISSUE cycle with k=3
      post(0, 8'h40, 3'd7);
      repeat (3) tick();
      reset = 1;
      tick();
      reset = 0;
      post(0, 8'h20, 3'd1);
      wait_idle();
      // Back-to-back single-word bursts
      b2b_mode = 1;
      req0_addr = 8'h77; req0_len = 3'd0; req0_valid = 1;
      repeat (40) tick();
      req0_valid = 0;
      b2b_mode = 0;
      wait_idle();
      // Random traffic with random backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (acc0) req0_valid = 0;
         if (acc1) req1_valid = 0;
         if (!req0_valid && $urandom_range(0, 2) == 0) begin
            req0_valid = 1; req0_addr = 8'($urandom); req0_len = 3'($urandom);
         end
         if (!req1_valid && $urandom_range(0, 2) == 0) begin
            req1_valid = 1; req1_addr = 8'($urandom); req1_len = 3'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 499) == 0);
      end
      reset = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;
      wait_idle();
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rom_burst_sched.md
# rom_burst_sched

Burst-read scheduler for the single-port 256×32 coefficient ROM that feeds the 8-lane matrix adder. Two requesters share the ROM. Each posts a base address and a burst length of 1–8 words. The block arbitrates round-robin, issues one ROM read per cycle with modulo-depth address wrap, and packs the returned words into an 8-word vector. That vector goes to the adder stage over a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, ROM word width
- ROM_DEPTH, 256, ROM words
- ADDR_WIDTH, $clog2(ROM_DEPTH), ROM address width
- BURST_MAX, 8, max words per burst / output slots

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request pending
- req0_addr  in  ADDR_WIDTH  requester 0 base address
- req0_len  in  3  requester 0 burst length minus 1
- req0_ready  out  1  request 0 accepted this cycle
- req1_valid / req1_addr / req1_len / req1_ready  same widths, same meaning as requester 0, for requester 1
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  DATA_WIDTH  ROM read data, valid one cycle after rom_en
- out_valid  out  1  packed burst available
- out_ready  in  1  consumer accepts packed burst
- out_data  out  BURST_MAX*DATA_WIDTH  word k at [k*DATA_WIDTH +: DATA_WIDTH]; unused slots are 0
- out_src  out  1  requester that owns out_data
- out_len  out  4  words in burst, 1..8
- busy  out  1  state != IDLE

## Operation
- **FSM states:** IDLE, ISSUE, DRAIN, HOLD.
- **IDLE – arbitration:**
  - Round-robin pointer `prio` is reset to 0.
  - If only one reqN_valid is high, grant it.
  - If both are high, grant `prio`.
  - The grant drives reqN_ready=1 combinationally for the granted requester only, in the same cycle.
- **IDLE – on grant:**
  - Latch addr, len+1, src.
  - Clear the slot buffer to 0 and set k=0.
  - Set `prio` = other requester.
  - Go to ISSUE.
- **ISSUE:**
  - rom_en=1, rom_addr=(base+k) mod ROM_DEPTH; natural ADDR_WIDTH overflow gives the wrap.
  - In each ISSUE cycle with k>0, capture rom_data into slot k-1.
  - After issuing k=len-1, go to DRAIN.
- **DRAIN:**
  - rom_en=0.
  - Capture rom_data into slot len-1.
  - Go to HOLD.
- **HOLD:**
  - out_valid=1; out_data, out_src and out_len stay stable.
  - On out_ready=1, go to IDLE.
- **Hold-off:** reqN_ready is 0 in every state except IDLE.
- **Requester obligations:** hold valid/addr/len stable until ready. The block never depends on out_ready to drive out_valid.
- rom_addr holds its last value when rom_en=0.
- **Reset (any state, including mid-burst):**
  - Next state IDLE, prio=0, slot buffer 0, and the in-flight burst is discarded.
  - Outputs go to reset values.
  - Any rom_data arriving after reset is ignored.

## Timing
- **Reset values:**
  - req0_ready=0, req1_ready=0, also while reset is high.
  - rom_en=0, rom_addr=0.
  - out_valid=0, out_data=0, out_src=0, out_len=0.
  - busy=0.
- **Burst schedule (accept in cycle T, L words):**
  - ISSUE in T+1..T+L.
  - DRAIN in T+L+1.
  - out_valid first high in T+L+2.
- **Handshake:** HOLD with out_ready=1 in cycle H gives IDLE in H+1. A new request can be accepted in H+1.
- **Back-to-back throughput:** L+3 cycles per burst.
- **ROM latency:** data for an address issued in cycle c is sampled at the end of cycle c+1. No ROM read is issued outside ISSUE.
- **Boundaries:**
  - len code 0 is a single word: ISSUE 1 cycle, DRAIN 1 cycle.
  - len code 7 fills all 8 slots.
  - A request arriving while busy waits in the requester. No queueing inside the block.

## Test plan
- **Single 8-word burst:** ROM model rom[a]=0x1000+a. req0 addr 0x10 len 7, accepted in T. Expect:
  - rom_addr 0x10..0x17 in T+1..T+8.
  - out_valid in T+10, slots 0x1010..0x1017, out_src=0, out_len=8.
- **Address wrap:** req1 addr 0xFE len 3. Expect:
  - rom_addr FE, FF, 00, 01.
  - Slots 0–3 = 0x10FE, 0x10FF, 0x1000, 0x1001; slots 4–7 = 0; out_src=1.
- **Arbitration:** both reqs held valid from reset with out_ready=1. Expect the grant sequence req0, req1, req0, req1, and never both ready in one cycle.
- **Backpressure:** out_ready=0 for 5 cycles in HOLD. Expect:
  - out_valid and out_data stable.
  - rom_en=0, both readies 0.
  - Release gives IDLE next cycle.
- **Mid-burst reset:** assert reset in the ISSUE cycle with k=3. Expect:
  - All outputs at reset values the next cycle.
  - A following req0 addr 0x20 len 1 gives a clean result: slots 0x1020, 0x1021, rest 0.
- **Back-to-back singles:** req0 len 0 with out_ready tied 1. Expect one accept every 4 cycles and out_len=1.
